// File: rtl/lfsr4_pkg.sv
// lfsr4_pkg: definitions shared by the 4-bit LFSR stream generator and its checker.
// Polynomial x^4+x^3+1, period 15. The output bit is s[3]^s[2] and the state
// shifts left with the new bit entering at s[0].
package lfsr4_pkg;

  localparam int LFSR_W    = 4;
  localparam int TAP_HI    = 3;
  localparam int TAP_LO    = 2;

  // Number of received bits needed before the shift register holds a full seed.
  localparam int FILL_FULL = LFSR_W;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } chk_state_t;

  // Next output bit predicted from the current LFSR state.
  function automatic logic lfsr_pred(input logic [LFSR_W-1:0] s);
    return s[TAP_HI] ^ s[TAP_LO];
  endfunction

  // Shift one bit into the LFSR state; s[0] always holds the newest bit.
  function automatic logic [LFSR_W-1:0] lfsr_shift(input logic [LFSR_W-1:0] s,
                                                   input logic b);
    return {s[LFSR_W-2:0], b};
  endfunction

endpackage

// File: rtl/lfsr4_step.sv
// lfsr4_step: combinational next-bit / next-state of the 4-bit LFSR.
// With use_ext low it free-runs (generator side, or the checker's flywheel);
// with use_ext high it shifts in an externally supplied bit instead.
module lfsr4_step
  import lfsr4_pkg::*;
(
  input  logic [LFSR_W-1:0] state,
  input  logic              ext_bit,
  input  logic              use_ext,
  output logic              pred,
  output logic [LFSR_W-1:0] next_state
);

  assign pred       = lfsr_pred(state);
  assign next_state = lfsr_shift(state, use_ext ? ext_bit : pred);

endmodule

// File: rtl/lfsr4_checker.sv
// lfsr4_checker: receive-side checker for the x^4+x^3+1 LFSR bit stream.
// HUNT fills a 4-bit seed from the line, SYNC confirms it over LOCK_CNT correct
// predictions, LOCKED flywheels the local LFSR and counts mismatched bits.
// Optional macro LFSR4_CHK_STUCK_EN adds the 'stuck' output and a run-length
// detector that drops lock when the line sits at a constant level.
module lfsr4_checker
  import lfsr4_pkg::*;
#(
  parameter int LOCK_CNT    = 8,
  parameter int LOSS_THRESH = 4,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             din_valid,
  input  logic             din,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err_pulse,
`ifdef LFSR4_CHK_STUCK_EN
  output logic             stuck,
`endif
  output logic [CNT_W-1:0] err_count
);

  localparam logic [7:0]       LOCK_TGT  = 8'(LOCK_CNT);
  localparam logic [3:0]       MISS_TGT  = 4'(LOSS_THRESH);
  localparam logic [2:0]       FILL_TGT  = 3'(FILL_FULL);
  localparam logic [2:0]       FILL_LAST = 3'(FILL_FULL - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  chk_state_t        state, state_nxt;
  logic [LFSR_W-1:0] sr, sr_nxt;
  logic [LFSR_W-1:0] step_state;
  logic [2:0]        fill_cnt, fill_nxt;
  logic [7:0]        match_cnt, match_nxt;
  logic [3:0]        miss_cnt, miss_nxt;
  logic              pred;
  logic              mismatch;
  logic              err_inc;
  logic              pulse_nxt;
  logic              locked_nxt;
  logic [CNT_W-1:0]  count_nxt;
  logic              force_hunt;

  // In LOCKED the register flywheels on its own prediction so a corrupted
  // line bit never enters the state; elsewhere the received bit is shifted in.
  lfsr4_step u_step (
    .state      (sr),
    .ext_bit    (din),
    .use_ext    (state != LOCKED),
    .pred       (pred),
    .next_state (step_state)
  );

  assign mismatch = din ^ pred;

`ifdef LFSR4_CHK_STUCK_EN
  // A legal stream never repeats a bit more than 4 times, so 8 is safely stuck.
  localparam int         STUCK_RUN = 8;
  localparam logic [3:0] RUN_TGT   = 4'(STUCK_RUN);

  logic [3:0] run_cnt, run_nxt;
  logic       last_bit;

  // Length of the current run of identical valid bits, saturating at RUN_TGT.
  always_comb begin
    run_nxt = run_cnt;
    if (en && din_valid) begin
      if ((run_cnt != 4'd0) && (din == last_bit)) begin
        if (run_cnt != RUN_TGT) begin
          run_nxt = run_cnt + 4'd1;
        end
      end else begin
        run_nxt = 4'd1;
      end
    end
  end

  // Run-length registers and the registered stuck flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_cnt  <= 4'd0;
      last_bit <= 1'b0;
      stuck    <= 1'b0;
    end else begin
      run_cnt <= run_nxt;
      stuck   <= (run_nxt == RUN_TGT);
      if (en && din_valid) begin
        last_bit <= din;
      end
    end
  end

  assign force_hunt = stuck;
`else
  assign force_hunt = 1'b0;
`endif

  // Next-state, shift register, progress counters and error strobe.
  always_comb begin
    state_nxt = state;
    sr_nxt    = sr;
    fill_nxt  = fill_cnt;
    match_nxt = match_cnt;
    miss_nxt  = miss_cnt;
    pulse_nxt = 1'b0;
    err_inc   = 1'b0;

    if (!en) begin
      state_nxt = HUNT;
      fill_nxt  = 3'd0;
      match_nxt = 8'd0;
      miss_nxt  = 4'd0;
    end else if (din_valid) begin
      sr_nxt = step_state;
      unique case (state)
        HUNT: begin
          if (fill_cnt != FILL_TGT) begin
            fill_nxt = fill_cnt + 3'd1;
          end
          // The all-zero state is the LFSR lockup point and can never seed a match.
          if ((fill_cnt >= FILL_LAST) && (step_state != '0)) begin
            state_nxt = SYNC;
            match_nxt = 8'd0;
          end
        end
        SYNC: begin
          if (mismatch) begin
            match_nxt = 8'd0;
          end else begin
            match_nxt = match_cnt + 8'd1;
            if (match_nxt == LOCK_TGT) begin
              state_nxt = LOCKED;
              match_nxt = 8'd0;
              miss_nxt  = 4'd0;
            end
          end
        end
        LOCKED: begin
          if (mismatch) begin
            pulse_nxt = 1'b1;
            err_inc   = 1'b1;
            miss_nxt  = miss_cnt + 4'd1;
            if (miss_nxt == MISS_TGT) begin
              state_nxt = HUNT;
              fill_nxt  = 3'd0;
              miss_nxt  = 4'd0;
            end
          end else begin
            miss_nxt = 4'd0;
          end
          if (force_hunt) begin
            state_nxt = HUNT;
            fill_nxt  = 3'd0;
            miss_nxt  = 4'd0;
          end
        end
        default: begin
          state_nxt = HUNT;
          fill_nxt  = 3'd0;
          match_nxt = 8'd0;
          miss_nxt  = 4'd0;
        end
      endcase
    end

    locked_nxt = (state_nxt == LOCKED);
  end

  // Saturating error counter; a clear coinciding with an error leaves exactly one.
  always_comb begin
    count_nxt = err_count;
    if (clr_cnt) begin
      count_nxt = err_inc ? CNT_ONE : '0;
    end else if (err_inc && (err_count != '1)) begin
      count_nxt = err_count + CNT_ONE;
    end
  end

  // FSM state register together with the shift register and progress counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= HUNT;
      sr        <= '0;
      fill_cnt  <= 3'd0;
      match_cnt <= 8'd0;
      miss_cnt  <= 4'd0;
    end else begin
      state     <= state_nxt;
      sr        <= sr_nxt;
      fill_cnt  <= fill_nxt;
      match_cnt <= match_nxt;
      miss_cnt  <= miss_nxt;
    end
  end

  // Registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      err_count <= '0;
    end else begin
      locked    <= locked_nxt;
      err_pulse <= pulse_nxt;
      err_count <= count_nxt;
    end
  end

endmodule

// File: tb/tb_lfsr4_checker.sv
// tb_lfsr4_checker: directed bench for lfsr4_checker with a scoreboard queue.
// The driver pushes the hand-derived expected outputs after each clock edge;
// a monitor on the falling edge pops and compares them.
// Build with LFSR4_CHK_STUCK_EN defined to also check the stuck output.
module tb_lfsr4_checker;

  localparam int CNT_W   = 3;
  localparam int CNT_MAX = 7;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             en;
  logic             din_valid;
  logic             din;
  logic             clr_cnt;
  logic             locked;
  logic             err_pulse;
  logic [CNT_W-1:0] err_count;
`ifdef LFSR4_CHK_STUCK_EN
  logic             stuck;
`endif

  typedef struct {
    logic  locked;
    logic  pulse;
    int    count;
    logic  stuck;
    logic  chk_stuck;
    string tag;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  int         total = 0;
  int         bad   = 0;
  logic [0:14] seq;
  int         gi   = 0;
  int         ecnt = 0;

  lfsr4_checker #(
    .LOCK_CNT    (8),
    .LOSS_THRESH (4),
    .CNT_W       (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .din_valid (din_valid),
    .din       (din),
    .clr_cnt   (clr_cnt),
    .locked    (locked),
    .err_pulse (err_pulse),
`ifdef LFSR4_CHK_STUCK_EN
    .stuck     (stuck),
`endif
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  function automatic logic streamBit(input int n);
    return seq[n % 15];
  endfunction

  function automatic exp_t mk(input logic l, input logic p, input int c, input string t);
    exp_t e;
    e.locked    = l;
    e.pulse     = p;
    e.count     = c;
    e.stuck     = 1'b0;
    e.chk_stuck = 1'b0;
    e.tag       = t;
    return e;
  endfunction

  task automatic checkOutput(input exp_t e);
    logic [CNT_W-1:0] want;
    want = e.count[CNT_W-1:0];
    total++;
    if (locked !== e.locked) begin
      bad++;
      $display("[TB] FAIL %s locked: got %0b want %0b", e.tag, locked, e.locked);
    end
    total++;
    if (err_pulse !== e.pulse) begin
      bad++;
      $display("[TB] FAIL %s err_pulse: got %0b want %0b", e.tag, err_pulse, e.pulse);
    end
    total++;
    if (err_count !== want) begin
      bad++;
      $display("[TB] FAIL %s err_count: got %0d want %0d", e.tag, err_count, want);
    end
`ifdef LFSR4_CHK_STUCK_EN
    if (e.chk_stuck) begin
      total++;
      if (stuck !== e.stuck) begin
        bad++;
        $display("[TB] FAIL %s stuck: got %0b want %0b", e.tag, stuck, e.stuck);
      end
    end
`endif
  endtask

  // Drive one cycle of inputs; queue the expected outputs once the edge has passed.
  task automatic applyStimulus(input logic d, input logic v, input logic c, input exp_t e);
    din       = d;
    din_valid = v;
    clr_cnt   = c;
    @(posedge clk);
    #1;
    sb.push_back(e);
    din_valid = 1'b0;
    clr_cnt   = 1'b0;
  endtask

  task automatic cleanBit(input logic l, input string t);
    applyStimulus(streamBit(gi), 1'b1, 1'b0, mk(l, 1'b0, ecnt, t));
    gi++;
  endtask

  task automatic flipBit(input logic l, input string t);
    if (ecnt < CNT_MAX) ecnt++;
    applyStimulus(~streamBit(gi), 1'b1, 1'b0, mk(l, 1'b1, ecnt, t));
    gi++;
  endtask

  task automatic alignLocked();
    while ((gi % 15) != 0) cleanBit(1'b1, "align");
  endtask

  // Assert reset between clock edges and check its effect without waiting for an edge.
  task automatic doReset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    ecnt = 0;
    checkOutput(mk(1'b0, 1'b0, 0, "async_reset"));
    @(negedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  // Scoreboard monitor: outputs are compared on the falling edge after each driven cycle.
  always @(negedge clk) begin
    if (sb.size() != 0) begin
      mon_e = sb.pop_front();
      checkOutput(mon_e);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    exp_t e;
    seq       = 15'b001101011110001;
    rst_n     = 1'b0;
    en        = 1'b1;
    din       = 1'b0;
    din_valid = 1'b0;
    clr_cnt   = 1'b0;
    #12;
    checkOutput(mk(1'b0, 1'b0, 0, "reset_state"));
    rst_n = 1'b1;

    $display("[TB] all-zero input from reset");
    for (int k = 0; k < 20; k++) begin
      e = mk(1'b0, 1'b0, 0, "zeros");
      e.stuck     = (k >= 7);
      e.chk_stuck = 1'b1;
      applyStimulus(1'b0, 1'b1, 1'b0, e);
    end
    doReset();

    $display("[TB] clean stream, lock after 12 bits");
    gi = 0;
    for (int k = 0; k < 100; k++) cleanBit(k >= 11, "clean_lock");

    $display("[TB] single inverted bit");
    alignLocked();
    flipBit(1'b1, "single_flip");
    for (int k = 0; k < 20; k++) cleanBit(1'b1, "after_flip");

    $display("[TB] clear alone, then four inverted bits");
    ecnt = 0;
    applyStimulus(streamBit(gi), 1'b1, 1'b1, mk(1'b1, 1'b0, 0, "clr_alone"));
    gi++;
    alignLocked();
    for (int k = 0; k < 4; k++) flipBit(k < 3, "loss_flip");
    for (int k = 0; k < 12; k++) cleanBit(k >= 11, "relock_loss");
    for (int k = 0; k < 3; k++) cleanBit(1'b1, "relocked");

    $display("[TB] error count saturation below loss threshold");
    for (int g = 0; g < 2; g++) begin
      alignLocked();
      for (int k = 0; k < 3; k++) flipBit(1'b1, "sat_flip");
    end
    cleanBit(1'b1, "sat_hold");

    $display("[TB] gapped stream with clear on an error");
    for (int k = 0; k < 16; k++) begin
      if (k == 6) begin
        ecnt = 1;
        applyStimulus(~streamBit(gi), 1'b1, 1'b1, mk(1'b1, 1'b1, 1, "clr_with_err"));
        gi++;
      end else begin
        cleanBit(1'b1, "gapped_bit");
      end
      applyStimulus(~streamBit(gi), 1'b0, 1'b0, mk(1'b1, 1'b0, ecnt, "gap"));
    end

    $display("[TB] enable low forces hunt");
    en = 1'b0;
    applyStimulus(streamBit(gi), 1'b1, 1'b0, mk(1'b0, 1'b0, ecnt, "en_low"));
    en = 1'b1;
    for (int k = 0; k < 12; k++) cleanBit(k >= 11, "relock_en");

    $display("[TB] asynchronous reset while locked");
    doReset();
    for (int k = 0; k < 14; k++) cleanBit(k >= 11, "relock_rst");

    for (int i = 0; i < 20 && sb.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("[TB] FAIL drain: got %0d pending want 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
